// File: rtl/pc_redirect_if.sv
// Redirect/fetch bundle between branch control, pipeline control and the PC owner.
interface pc_redirect_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              le;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_target;
  logic              redirect_cond;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] npc;
  logic              fetch_valid;
  logic              flush_if;
  logic              in_delay_slot;
  logic              pending;
  logic              misalign;

  modport master (
    output le, redirect_valid, redirect_target, redirect_cond,
    input  pc, npc, fetch_valid, flush_if, in_delay_slot, pending, misalign
  );

  modport slave (
    input  le, redirect_valid, redirect_target, redirect_cond,
    output pc, npc, fetch_valid, flush_if, in_delay_slot, pending, misalign
  );
endinterface

// File: rtl/pc_redirect_unit.sv
// Architectural PC/nPC owner: applies branch/jump redirects with a one-instruction
// delay slot and buffers a single redirect across pipeline stalls.
module pc_redirect_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       STEP     = 4
) (
  input logic           clk,
  input logic           rst_n,
  pc_redirect_if.slave  bus
);
  typedef enum logic [1:0] {BOOT, RUN, HOLD, SLOT} state_t;

  localparam logic [ADDR_W-1:0] STEP_W = ADDR_W'(STEP);

  state_t            state;
  logic [ADDR_W-1:0] pc_q, npc_q, buf_target;
  logic              buf_cond, pending_q;

  logic [ADDR_W-1:0] live_target, apply_target;
  logic              apply, apply_cond, capture, live_take;

  assign live_target = {bus.redirect_target[ADDR_W-1:2], 2'b00};

  // apply: redirect takes effect at this edge; capture: redirect goes into the buffer.
  always_comb begin
    apply        = 1'b0;
    apply_cond   = 1'b0;
    apply_target = live_target;
    capture      = 1'b0;
    case (state)
      RUN: begin
        if (bus.redirect_valid) begin
          if (bus.le) begin
            apply      = 1'b1;
            apply_cond = bus.redirect_cond;
          end else begin
            capture = 1'b1;
          end
        end
      end
      HOLD: begin
        if (bus.le) begin
          apply        = 1'b1;
          apply_cond   = buf_cond;
          apply_target = buf_target;
        end else if (bus.redirect_valid && (bus.redirect_cond || !buf_cond)) begin
          capture = 1'b1;
        end
      end
      SLOT: begin
        // Only a branch resolved in EX can override the pending jump target.
        if (bus.redirect_valid && bus.redirect_cond) begin
          if (bus.le) begin
            apply      = 1'b1;
            apply_cond = 1'b1;
          end else begin
            capture = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign live_take = (apply && state != HOLD) || capture;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= BOOT;
      pc_q       <= RESET_PC;
      npc_q      <= RESET_PC + STEP_W;
      buf_target <= '0;
      buf_cond   <= 1'b0;
      pending_q  <= 1'b0;
    end else if (state == BOOT) begin
      state <= RUN;
    end else if (apply) begin
      pending_q <= 1'b0;
      if (apply_cond) begin
        pc_q  <= apply_target;
        npc_q <= apply_target + STEP_W;
        state <= RUN;
      end else begin
        pc_q  <= npc_q;
        npc_q <= apply_target;
        state <= SLOT;
      end
    end else if (capture) begin
      buf_target <= live_target;
      buf_cond   <= bus.redirect_cond;
      pending_q  <= 1'b1;
      state      <= HOLD;
    end else if (bus.le) begin
      pc_q  <= npc_q;
      npc_q <= npc_q + STEP_W;
      state <= RUN;
    end
  end

  assign bus.pc            = pc_q;
  assign bus.npc           = npc_q;
  assign bus.pending       = pending_q;
  assign bus.fetch_valid   = (state != BOOT);
  assign bus.in_delay_slot = (state == SLOT);
  assign bus.flush_if      = rst_n && apply && apply_cond;
  assign bus.misalign      = rst_n && live_take && (bus.redirect_target[1:0] != 2'b00);
endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed checks of pc_redirect_unit: boot, jumps with delay slot, branches,
// stall buffering, slot preemption, wrap/alignment and reset during a stall.
module tb_pc_redirect_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  pc_redirect_if #(.ADDR_W(32)) bus ();

  pc_redirect_unit #(
    .ADDR_W  (32),
    .RESET_PC(32'h0000_0000),
    .STEP    (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic le, input logic v, input logic cond, input logic [31:0] tgt);
    bus.le              = le;
    bus.redirect_valid  = v;
    bus.redirect_cond   = cond;
    bus.redirect_target = tgt;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    tick(); tick();
    checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want %h", bus.pc, 32'h0); end
    checks++; if (bus.npc !== 32'h4) begin errors++; $display("FAIL reset_npc: got %h want %h", bus.npc, 32'h4); end
    checks++; if ({bus.fetch_valid, bus.pending, bus.in_delay_slot, bus.flush_if, bus.misalign} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 00000", {bus.fetch_valid, bus.pending, bus.in_delay_slot, bus.flush_if, bus.misalign}); end
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 32'h500);
    checks++; if (bus.flush_if !== 1'b0) begin errors++; $display("FAIL boot_flush: got %b want 0", bus.flush_if); end
    tick();
    checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL boot_pc: got %h want %h", bus.pc, 32'h0); end
    checks++; if (bus.fetch_valid !== 1'b1) begin errors++; $display("FAIL boot_fetch_valid: got %b want 1", bus.fetch_valid); end
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    checks++; if (bus.pc !== 32'h4) begin errors++; $display("FAIL seq_pc1: got %h want %h", bus.pc, 32'h4); end
    tick();
    checks++; if (bus.pc !== 32'h8) begin errors++; $display("FAIL seq_pc2: got %h want %h", bus.pc, 32'h8); end
  endtask

  task automatic test_jump();
    tick(); tick();
    checks++; if (bus.pc !== 32'h10) begin errors++; $display("FAIL jump_start_pc: got %h want %h", bus.pc, 32'h10); end
    drive(1'b1, 1'b1, 1'b0, 32'h100);
    checks++; if (bus.flush_if !== 1'b0) begin errors++; $display("FAIL jump_flush: got %b want 0", bus.flush_if); end
    tick();
    checks++; if (bus.pc !== 32'h14 || bus.npc !== 32'h100) begin errors++; $display("FAIL jump_slot_pc: got %h/%h want 00000014/00000100", bus.pc, bus.npc); end
    checks++; if (bus.in_delay_slot !== 1'b1) begin errors++; $display("FAIL jump_in_slot: got %b want 1", bus.in_delay_slot); end
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    checks++; if (bus.pc !== 32'h100 || bus.npc !== 32'h104) begin errors++; $display("FAIL jump_target_pc: got %h/%h want 00000100/00000104", bus.pc, bus.npc); end
    checks++; if (bus.in_delay_slot !== 1'b0) begin errors++; $display("FAIL jump_slot_clear: got %b want 0", bus.in_delay_slot); end
  endtask

  task automatic test_branch();
    drive(1'b1, 1'b1, 1'b1, 32'h20);
    checks++; if (bus.flush_if !== 1'b1) begin errors++; $display("FAIL br1_flush: got %b want 1", bus.flush_if); end
    tick();
    checks++; if (bus.pc !== 32'h20 || bus.npc !== 32'h24) begin errors++; $display("FAIL br1_pc: got %h/%h want 00000020/00000024", bus.pc, bus.npc); end
    drive(1'b1, 1'b1, 1'b1, 32'h200);
    checks++; if (bus.flush_if !== 1'b1) begin errors++; $display("FAIL br2_flush: got %b want 1", bus.flush_if); end
    tick();
    checks++; if (bus.pc !== 32'h200 || bus.npc !== 32'h204) begin errors++; $display("FAIL br2_pc: got %h/%h want 00000200/00000204", bus.pc, bus.npc); end
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    checks++; if (bus.flush_if !== 1'b0) begin errors++; $display("FAIL br2_flush_drop: got %b want 0", bus.flush_if); end
  endtask

  task automatic test_hold();
    drive(1'b0, 1'b1, 1'b0, 32'h300);
    checks++; if (bus.flush_if !== 1'b0) begin errors++; $display("FAIL hold_stall_flush: got %b want 0", bus.flush_if); end
    tick();
    checks++; if (bus.pending !== 1'b1) begin errors++; $display("FAIL hold_pending: got %b want 1", bus.pending); end
    checks++; if (bus.pc !== 32'h200 || bus.npc !== 32'h204) begin errors++; $display("FAIL hold_pc: got %h/%h want 00000200/00000204", bus.pc, bus.npc); end
    drive(1'b0, 1'b1, 1'b1, 32'h400);
    checks++; if (bus.flush_if !== 1'b0) begin errors++; $display("FAIL hold_stall_flush2: got %b want 0", bus.flush_if); end
    tick();
    checks++; if (bus.pending !== 1'b1 || bus.pc !== 32'h200) begin errors++; $display("FAIL hold_pending2: got %b/%h want 1/00000200", bus.pending, bus.pc); end
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    checks++; if (bus.flush_if !== 1'b1) begin errors++; $display("FAIL hold_release_flush: got %b want 1", bus.flush_if); end
    tick();
    checks++; if (bus.pc !== 32'h400 || bus.npc !== 32'h404) begin errors++; $display("FAIL hold_release_pc: got %h/%h want 00000400/00000404", bus.pc, bus.npc); end
    checks++; if (bus.pending !== 1'b0) begin errors++; $display("FAIL hold_pending_clear: got %b want 0", bus.pending); end
    // buffered branch must not be displaced by a later jump
    drive(1'b0, 1'b1, 1'b1, 32'h500); tick();
    drive(1'b0, 1'b1, 1'b0, 32'h600); tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0); tick();
    checks++; if (bus.pc !== 32'h500 || bus.npc !== 32'h504) begin errors++; $display("FAIL hold_drop_jump: got %h/%h want 00000500/00000504", bus.pc, bus.npc); end
    // buffered jump keeps the delay slot; live redirect on release is ignored
    drive(1'b0, 1'b1, 1'b0, 32'h700); tick();
    drive(1'b1, 1'b1, 1'b1, 32'h900);
    checks++; if (bus.flush_if !== 1'b0) begin errors++; $display("FAIL hold_jump_flush: got %b want 0", bus.flush_if); end
    tick();
    checks++; if (bus.pc !== 32'h504 || bus.npc !== 32'h700 || bus.in_delay_slot !== 1'b1) begin
      errors++; $display("FAIL hold_jump_slot: got %h/%h/%b want 00000504/00000700/1", bus.pc, bus.npc, bus.in_delay_slot); end
    drive(1'b1, 1'b0, 1'b0, 32'h0); tick();
    checks++; if (bus.pc !== 32'h700 || bus.npc !== 32'h704) begin errors++; $display("FAIL hold_jump_target: got %h/%h want 00000700/00000704", bus.pc, bus.npc); end
  endtask

  task automatic test_slot_preempt();
    drive(1'b1, 1'b1, 1'b0, 32'h800); tick();
    checks++; if (bus.pc !== 32'h704 || bus.npc !== 32'h800) begin errors++; $display("FAIL slot_enter: got %h/%h want 00000704/00000800", bus.pc, bus.npc); end
    drive(1'b1, 1'b1, 1'b1, 32'hA00);
    checks++; if (bus.flush_if !== 1'b1) begin errors++; $display("FAIL slot_preempt_flush: got %b want 1", bus.flush_if); end
    tick();
    checks++; if (bus.pc !== 32'hA00 || bus.npc !== 32'hA04 || bus.in_delay_slot !== 1'b0) begin
      errors++; $display("FAIL slot_preempt_pc: got %h/%h/%b want 00000a00/00000a04/0", bus.pc, bus.npc, bus.in_delay_slot); end
    drive(1'b1, 1'b1, 1'b0, 32'hB00); tick();
    drive(1'b1, 1'b1, 1'b0, 32'hC00); tick();
    checks++; if (bus.pc !== 32'hB00 || bus.npc !== 32'hB04) begin errors++; $display("FAIL slot_jump_ignored: got %h/%h want 00000b00/00000b04", bus.pc, bus.npc); end
  endtask

  task automatic test_wrap_align();
    drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8); tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0); tick();
    checks++; if (bus.pc !== 32'hFFFF_FFFC || bus.npc !== 32'h0) begin errors++; $display("FAIL wrap_pc1: got %h/%h want fffffffc/00000000", bus.pc, bus.npc); end
    tick();
    checks++; if (bus.pc !== 32'h0 || bus.npc !== 32'h4) begin errors++; $display("FAIL wrap_pc2: got %h/%h want 00000000/00000004", bus.pc, bus.npc); end
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0103);
    checks++; if (bus.misalign !== 1'b1) begin errors++; $display("FAIL misalign_pulse: got %b want 1", bus.misalign); end
    tick();
    checks++; if (bus.pc !== 32'h100 || bus.npc !== 32'h104) begin errors++; $display("FAIL misalign_pc: got %h/%h want 00000100/00000104", bus.pc, bus.npc); end
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    checks++; if (bus.misalign !== 1'b0) begin errors++; $display("FAIL misalign_clear: got %b want 0", bus.misalign); end
  endtask

  task automatic test_reset_in_hold();
    drive(1'b0, 1'b1, 1'b1, 32'h700); tick();
    checks++; if (bus.pending !== 1'b1) begin errors++; $display("FAIL rsthold_pending: got %b want 1", bus.pending); end
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 32'h0); tick();
    checks++; if (bus.pending !== 1'b0 || bus.pc !== 32'h0 || bus.fetch_valid !== 1'b0) begin
      errors++; $display("FAIL rsthold_state: got %b/%h/%b want 0/00000000/0", bus.pending, bus.pc, bus.fetch_valid); end
    rst_n = 1'b1;
    tick();
    checks++; if (bus.pc !== 32'h0 || bus.fetch_valid !== 1'b1) begin errors++; $display("FAIL rsthold_boot: got %h/%b want 00000000/1", bus.pc, bus.fetch_valid); end
    tick();
    checks++; if (bus.pc !== 32'h4 || bus.npc !== 32'h8) begin errors++; $display("FAIL rsthold_no_stale: got %h/%h want 00000004/00000008", bus.pc, bus.npc); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_jump();
    test_branch();
    test_hold();
    test_slot_preempt();
    test_wrap_align();
    test_reset_in_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Consumer end of the branch/jump redirect path.
- Owns the architectural PC/nPC pair that feeds instruction fetch.
- Accepts the resolved "take target" decision and its target address from branch control, honours the one-instruction delay slot, and buffers redirects that arrive during pipeline stalls.
- Drives the IF/ID squash signal.

Parameters:
- ADDR_W, 32, width of PC, nPC and target.
- RESET_PC, 32'h0000_0000, PC value after reset; nPC resets to RESET_PC+4.
- STEP, 4, byte increment per sequential instruction.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- le  input  1  pipeline load enable; 0 = stall, PC/nPC hold.
- redirect_valid  input  1  branch control asserts "take target" this cycle.
- redirect_target  input  ADDR_W  target address (TA or register value).
- redirect_cond  input  1  1 = conditional branch resolved in EX; 0 = unconditional jump resolved in ID.
- pc  output  ADDR_W  current fetch address.
- npc  output  ADDR_W  next fetch address.
- fetch_valid  output  1  pc is a real fetch.
- flush_if  output  1  squash the instruction currently in IF/ID.
- in_delay_slot  output  1  instruction now fetched at pc is a delay slot.
- pending  output  1  one redirect is buffered awaiting le.
- misalign  output  1  one-cycle pulse when target[1:0] != 0.

Behaviour:
- Reset (rst_n=0 at a clock edge): pc=RESET_PC, npc=RESET_PC+STEP. All 1-bit outputs 0. Pending buffer cleared. State=BOOT. Overrides any in-flight redirect, stall or buffered entry.
- FSM states: BOOT, RUN, HOLD, SLOT.
- BOOT: lasts exactly one cycle after rst_n rises. fetch_valid=0. Next state RUN regardless of le. Redirects presented in BOOT are ignored.
- RUN: fetch_valid=1.
  - le=1, no redirect: pc<=npc, npc<=npc+STEP.
  - le=1, redirect_cond=0: pc<=npc (delay slot kept), npc<=target. Next state SLOT.
  - le=1, redirect_cond=1: delay slot is already in ID, so the IF instruction is wrong-path. flush_if=1 that cycle, pc<=target, npc<=target+STEP. Stay in RUN.
  - le=0 with a redirect: capture {target, cond} into the buffer, pending<=1, next state HOLD. pc/npc hold.
  - le=0, no redirect: hold.
- HOLD: pc/npc hold while le=0.
  - A new redirect while a buffered one is pending: cond=1 replaces the buffer (EX is older in program order). cond=0 is dropped when the buffer holds a cond=1 entry; otherwise it replaces the buffer.
  - When le=1, apply the buffered entry exactly as RUN would. Clear pending. A live redirect_valid in that same cycle is ignored.
- SLOT: in_delay_slot=1. Next le=1 advances pc<=npc (target), npc<=target+STEP, then return to RUN.
  - A cond=1 redirect arriving in SLOT is applied and preempts the pending jump target (flush_if=1).
  - A cond=0 redirect arriving in SLOT is ignored (a jump in a delay slot is undefined; dropped).
  - le=0 holds SLOT.
- Alignment: target low 2 bits are forced to 0 before use. misalign pulses for one cycle on the cycle the target is consumed or buffered.
- Arithmetic: all additions are modulo 2^ADDR_W. pc=32'hFFFF_FFFC advances to 32'h0000_0000 with no flag.
- flush_if is asserted only in the cycle a cond=1 redirect is applied (live or from the buffer). It is never asserted during stall cycles.
- Latency: a redirect presented with le=1 is visible on pc/npc the next clock edge. A buffered redirect is visible one edge after le returns to 1.

Test Plan:
- Reset then 3 cycles le=1, no redirect -> fetch_valid 0 for 1 cycle; pc then steps 0x0, 0x4, 0x8.
- At pc=0x10, npc=0x14: redirect_valid=1, cond=0, target=0x100 -> next pc=0x14, in_delay_slot=1, npc=0x100; following edge pc=0x100, npc=0x104.
- At pc=0x20: cond=1, target=0x200 -> flush_if=1 that cycle; next pc=0x200, npc=0x204.
- le=0, cond=0 target 0x300, then cond=1 target 0x400 while held, then le=1 -> pending=1 during hold; pc=0x400, npc=0x404, flush_if=1 on the release cycle.
- pc=0xFFFF_FFF8 sequential; target=0x0000_0103 -> pc wraps 0xFFFF_FFFC to 0x0; target applied as 0x100, misalign pulses once.
- rst_n=0 while in HOLD with pending=1 -> pending=0, pc=RESET_PC, state BOOT; buffered target never appears.
